// File: rtl/vtg_pkg.sv
// rtl/vtg_pkg.sv - pattern enum, bar colour table and timing presets for video_timing_gen
package vtg_pkg;

    typedef enum logic [1:0] {
        PAT_SOLID  = 2'd0,
        PAT_STRIPE = 2'd1,
        PAT_BARS   = 2'd2,
        PAT_CHECK  = 2'd3
    } pattern_e;

    localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
    localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RGB_RED     = 24'hFF0000;
    localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
    localparam logic [23:0] RGB_BLACK   = 24'h000000;

    // Index 0 is the leftmost bar on screen.
    localparam logic [7:0][23:0] BAR_COLOURS = {
        RGB_BLACK, RGB_BLUE, RGB_RED, RGB_MAGENTA,
        RGB_GREEN, RGB_CYAN, RGB_YELLOW, RGB_WHITE
    };

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } vtg_timing_t;

    localparam vtg_timing_t VTG_640X480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33
    };

    localparam vtg_timing_t VTG_800X600_60 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23
    };

    function automatic int vtg_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vtg_pattern.sv
// rtl/vtg_pattern.sv - registered test pattern generator, instantiated only when VTG_PATTERN_EN is defined
module vtg_pattern
    import vtg_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int COORD_W  = 12
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [1:0]         pattern_sel,
    input  logic [COORD_W-1:0] h_cnt,
    input  logic [COORD_W-1:0] v_cnt,
    input  logic               active,
    output logic [23:0]        rgb
);

    localparam logic [COORD_W-1:0] BAR_LAST = COORD_W'(H_ACTIVE / 8 - 1);

    generate
        if (COORD_W < 5) begin : g_coord_w_check
            $fatal(1, "vtg_pattern: COORD_W must be at least 5 for the 16x16 checker");
        end
    endgenerate

    pattern_e           pat_q;
    pattern_e           pat_cur;
    logic               line_start;
    logic               frame_origin;
    logic [COORD_W-1:0] bar_px_q;
    logic [COORD_W-1:0] bar_px_cur;
    logic [2:0]         bar_idx_q;
    logic [2:0]         bar_idx_cur;
    logic [23:0]        rgb_next;

    // Pattern is latched at the frame origin so one frame never mixes patterns;
    // the bar counter is forced to zero on the first pixel of every line.
    always_comb begin
        line_start   = (h_cnt == '0);
        frame_origin = line_start && (v_cnt == '0);
        pat_cur      = frame_origin ? pattern_e'(pattern_sel) : pat_q;
        bar_px_cur   = line_start ? '0 : bar_px_q;
        bar_idx_cur  = line_start ? '0 : bar_idx_q;
    end

    // Colour for the current counter position; black outside the active region.
    always_comb begin
        rgb_next = RGB_BLACK;
        if (active) begin
            case (pat_cur)
                PAT_SOLID:  rgb_next = RGB_WHITE;
                PAT_STRIPE: rgb_next = v_cnt[1] ? RGB_RED : RGB_GREEN;
                PAT_BARS:   rgb_next = BAR_COLOURS[bar_idx_cur];
                PAT_CHECK:  rgb_next = (h_cnt[4] ^ v_cnt[4]) ? RGB_WHITE : RGB_BLACK;
                default:    rgb_next = RGB_BLACK;
            endcase
        end
    end

    // Pattern register, per-line bar counter and the rgb output stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q     <= PAT_SOLID;
            bar_px_q  <= '0;
            bar_idx_q <= '0;
            rgb       <= '0;
        end else if (enable) begin
            pat_q <= pat_cur;
            if (bar_px_cur == BAR_LAST) begin
                bar_px_q  <= '0;
                bar_idx_q <= bar_idx_cur + 3'd1;
            end else begin
                bar_px_q  <= bar_px_cur + COORD_W'(1);
                bar_idx_q <= bar_idx_cur;
            end
            rgb <= rgb_next;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - video timing generator top; test pattern built only when VTG_PATTERN_EN is defined
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int COORD_W   = 12
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [1:0]         pattern_sel,
    output logic               de,
    output logic               hsync,
    output logic               vsync,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [23:0]        rgb,
    output logic               frame_start,
    output logic [15:0]        frame_cnt
);

    localparam int H_TOTAL = vtg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vtg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    generate
        if ((H_ACTIVE % 8) != 0) begin : g_h_active_check
            $fatal(1, "video_timing_gen: H_ACTIVE must be a multiple of 8");
        end
        if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
            V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero_check
            $fatal(1, "video_timing_gen: timing parameters must be non-zero");
        end
        if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_coord_check
            $fatal(1, "video_timing_gen: line or frame total does not fit in COORD_W");
        end
    endgenerate

    localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT_END = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_END = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START  = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END    = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START  = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END    = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic               h_last;
    logic               v_last;
    logic               active;
    logic               hs_on;
    logic               vs_on;

    // Region decode of the current counter position.
    always_comb begin
        h_last = (h_cnt == H_LAST);
        v_last = (v_cnt == V_LAST);
        active = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        hs_on  = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs_on  = (v_cnt >= VS_START) && (v_cnt < VS_END);
    end

    // Raster counters: h advances every enabled cycle, v advances on h wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (enable) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + COORD_W'(1);
            end else begin
                h_cnt <= h_cnt + COORD_W'(1);
            end
        end
    end

    // Output stage: every output reflects the counter state of the previous enabled edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            de          <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else if (enable) begin
            de          <= active;
            hsync       <= hs_on ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= vs_on ? VSYNC_POL : ~VSYNC_POL;
            pix_x       <= active ? h_cnt : '0;
            pix_y       <= active ? v_cnt : '0;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            if (h_last && v_last) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

`ifdef VTG_PATTERN_EN
    vtg_pattern #(
        .H_ACTIVE (H_ACTIVE),
        .COORD_W  (COORD_W)
    ) u_pattern (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .active      (active),
        .rgb         (rgb)
    );
`else
    logic unused_pattern_sel;
    assign unused_pattern_sel = ^pattern_sel;
    assign rgb = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - randomized self-checking bench for video_timing_gen against a pixel-index model
module tb_video_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int CW = 5;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

`ifdef VTG_PATTERN_EN
    localparam bit PAT_ON = 1'b1;
`else
    localparam bit PAT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    pattern_sel = 2'd0;

    logic          de0, hsync0, vsync0, fs0;
    logic [CW-1:0] pix_x0, pix_y0;
    logic [23:0]   rgb0;
    logic [15:0]   fcnt0;
    logic          de1, hsync1, vsync1, fs1;
    logic [CW-1:0] pix_x1, pix_y1;
    logic [23:0]   rgb1;
    logic [15:0]   fcnt1;

    int total = 0;
    int bad = 0;
    int de_hits = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COORD_W(CW)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pattern_sel(pattern_sel),
        .de(de0), .hsync(hsync0), .vsync(vsync0), .pix_x(pix_x0), .pix_y(pix_y0),
        .rgb(rgb0), .frame_start(fs0), .frame_cnt(fcnt0)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COORD_W(CW)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pattern_sel(pattern_sel),
        .de(de1), .hsync(hsync1), .vsync(vsync1), .pix_x(pix_x1), .pix_y(pix_y1),
        .rgb(rgb1), .frame_start(fs1), .frame_cnt(fcnt1)
    );

    typedef struct packed {
        logic          de;
        logic          hs_act;
        logic          vs_act;
        logic [CW-1:0] px;
        logic [CW-1:0] py;
        logic [23:0]   rgb;
        logic          fs;
    } beat_t;

    localparam beat_t IDLE_BEAT = '0;

    function automatic logic [23:0] pattern_colour(input logic [1:0] pat, input int x, input int y);
        logic [23:0] c;
        case (pat)
            2'd0: c = 24'hFFFFFF;
            2'd1: c = (((y / 2) % 2) == 1) ? 24'hFF0000 : 24'h00FF00;
            2'd2: begin
                case (x / (HA / 8))
                    0: c = 24'hFFFFFF;
                    1: c = 24'hFFFF00;
                    2: c = 24'h00FFFF;
                    3: c = 24'h00FF00;
                    4: c = 24'hFF00FF;
                    5: c = 24'hFF0000;
                    6: c = 24'h0000FF;
                    default: c = 24'h000000;
                endcase
            end
            default: c = ((((x / 16) + (y / 16)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
        endcase
        return c;
    endfunction

    // Expected beat for the p-th pixel since reset, using pattern pat.
    function automatic beat_t model_beat(input int p, input logic [1:0] pat);
        beat_t b;
        int h;
        int v;
        h = p % HT;
        v = (p / HT) % VT;
        b = '0;
        b.de     = (h < HA) && (v < VA);
        b.hs_act = (h >= HA + HF) && (h < HA + HF + HS);
        b.vs_act = (v >= VA + VF) && (v < VA + VF + VS);
        b.fs     = (h == 0) && (v == 0);
        if (b.de) begin
            b.px  = CW'(h);
            b.py  = CW'(v);
            b.rgb = PAT_ON ? pattern_colour(pat, h, v) : 24'h0;
        end
        return b;
    endfunction

    int          mp = 0;
    logic [1:0]  mpat = 2'd0;
    beat_t       exp_b = IDLE_BEAT;
    logic [15:0] exp_frames = '0;
    logic [15:0] fcnt_ofs = '0;
    logic [15:0] exp_fcnt_now;

    assign exp_fcnt_now = exp_frames + fcnt_ofs;

    // Reference: pixel index advances on enabled edges; pattern captured at each frame origin.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mp         <= 0;
            mpat       <= 2'd0;
            exp_b      <= IDLE_BEAT;
            exp_frames <= '0;
        end else if (enable) begin
            exp_b <= model_beat(mp, ((mp % FT) == 0) ? pattern_sel : mpat);
            if ((mp % FT) == 0) mpat <= pattern_sel;
            if ((mp % FT) == FT - 1) exp_frames <= exp_frames + 16'd1;
            mp <= mp + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Every cycle, both instances against the model.
    always @(negedge clk) begin
        chk("de",          32'(de0),    32'(exp_b.de));
        chk("hsync",       32'(hsync0), 32'(!exp_b.hs_act));
        chk("vsync",       32'(vsync0), 32'(!exp_b.vs_act));
        chk("pix_x",       32'(pix_x0), 32'(exp_b.px));
        chk("pix_y",       32'(pix_y0), 32'(exp_b.py));
        chk("rgb",         32'(rgb0),   32'(exp_b.rgb));
        chk("frame_start", 32'(fs0),    32'(exp_b.fs));
        chk("frame_cnt",   32'(fcnt0),  32'(exp_fcnt_now));
        chk("de_p1",       32'(de1),    32'(exp_b.de));
        chk("hsync_p1",    32'(hsync1), 32'(exp_b.hs_act));
        chk("vsync_p1",    32'(vsync1), 32'(exp_b.vs_act));
        chk("pix_x_p1",    32'(pix_x1), 32'(exp_b.px));
        chk("pix_y_p1",    32'(pix_y1), 32'(exp_b.py));
        chk("rgb_p1",      32'(rgb1),   32'(exp_b.rgb));
        chk("fs_p1",       32'(fs1),    32'(exp_b.fs));
        chk("fcnt_p1",     32'(fcnt1),  32'(exp_frames));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        enable = 1'b0;
        pattern_sel = 2'd0;
        repeat (3) step();
        chk("rst_de", 32'(de0), 0);
        chk("rst_hsync_idle_p0", 32'(hsync0), 1);
        chk("rst_vsync_idle_p0", 32'(vsync0), 1);
        chk("rst_hsync_idle_p1", 32'(hsync1), 0);
        chk("rst_vsync_idle_p1", 32'(vsync1), 0);

        // First frame, beat k is pixel k.
        reset_n = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < FT; k++) begin
            step();
            if (k == 0) begin
                chk("first_de", 32'(de0), 1);
                chk("first_pix_x", 32'(pix_x0), 0);
                chk("first_pix_y", 32'(pix_y0), 0);
                chk("first_fs", 32'(fs0), 1);
                chk("first_fcnt", 32'(fcnt0), 0);
            end
            if (k < HT && de0) de_hits++;
            if (k == 9)  chk("hsync_h9", 32'(hsync0), 1);
            if (k == 10) chk("hsync_h10", 32'(hsync0), 0);
            if (k == 10) chk("hsync_h10_p1", 32'(hsync1), 1);
            if (k == 12) chk("hsync_h12", 32'(hsync0), 0);
            if (k == 13) chk("hsync_h13", 32'(hsync0), 1);
            if (k == 4 * HT + 15) chk("vsync_v4", 32'(vsync0), 1);
            if (k == 5 * HT) chk("vsync_v5", 32'(vsync0), 0);
            if (k == 6 * HT + 15) chk("vsync_v6", 32'(vsync0), 0);
            if (k == 7 * HT) chk("vsync_v7", 32'(vsync0), 1);
            if (k == FT - 2) chk("fcnt_edge127", 32'(fcnt0), 0);
            if (k == FT - 1) chk("fcnt_edge128", 32'(fcnt0), 1);
        end
        chk("de_per_line", de_hits, 8);

        // Enable pattern 1,0,0,1 starting on the origin of frame 1.
        step();
        chk("fs_frame1", 32'(fs0), 1);
        enable = 1'b0;
        step();
        chk("hold1_fs", 32'(fs0), 1);
        step();
        chk("hold2_fs", 32'(fs0), 1);
        chk("hold2_pix_x", 32'(pix_x0), 0);
        enable = 1'b1;
        step();
        chk("resume_pix_x", 32'(pix_x0), 1);
        chk("resume_fs", 32'(fs0), 0);

        // Beat 129 shown; advance to counters at (3,1) and request bars.
        repeat (17) step();
        pattern_sel = 2'd2;
        for (int b = 147; b < 264; b++) begin
            step();
            if (b == FT + 2 * HT + 3) chk("solid_kept", 32'(rgb0), PAT_ON ? 32'hFFFFFF : 32'h0);
            if (b == 2 * FT) chk("bars_x0", 32'(rgb0), PAT_ON ? 32'hFFFFFF : 32'h0);
            if (b == 2 * FT) chk("fcnt_frame2", 32'(fcnt0), 2);
            if (b == 2 * FT + 1) chk("bars_x1", 32'(rgb0), PAT_ON ? 32'hFFFF00 : 32'h0);
            if (b == 2 * FT + 7) chk("bars_x7", 32'(rgb0), 32'h0);
        end

        // Reset mid-frame at (5,2).
        for (int b = 264; b <= 2 * FT + 2 * HT + 5; b++) step();
        reset_n = 1'b0;
        #1;
        chk("abort_de", 32'(de0), 0);
        chk("abort_pix_x", 32'(pix_x0), 0);
        chk("abort_pix_y", 32'(pix_y0), 0);
        chk("abort_rgb", 32'(rgb0), 0);
        chk("abort_fcnt", 32'(fcnt0), 0);
        chk("abort_hsync_p1", 32'(hsync1), 0);
        step();
        reset_n = 1'b1;
        step();
        chk("restart_fs", 32'(fs0), 1);
        chk("restart_pix_x", 32'(pix_x0), 0);
        chk("restart_fcnt", 32'(fcnt0), 0);

        // Randomized enable, pattern requests and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) pattern_sel = 2'($urandom_range(0, 3));
            reset_n = ($urandom_range(0, 599) != 0);
            step();
        end

        // Frame counter rollover from a preloaded FFFF.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        enable = 1'b1;
        repeat (FT - 2) step();
        force dut0.frame_cnt = 16'hFFFF;
        fcnt_ofs = 16'hFFFF;
        #1;
        release dut0.frame_cnt;
        step();
        chk("fcnt_preload", 32'(fcnt0), 32'hFFFF);
        step();
        chk("fcnt_rollover", 32'(fcnt0), 32'h0);
        step();
        chk("fs_after_rollover", 32'(fs0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
